parity_serial_tx: RTL and testbench

- Serial frame transmitter. Accepts a parallel data word over a valid/ready handshake.
- Shifts out the frame LSB first: start bit, data bits, parity bit, stop bit.
- Parity bit is the XNOR-reduction of the data word, which gives odd parity.
- This is the sending end for the team's XNOR-based equality/parity checker receivers. It feeds their serial input directly.

---
 rtl/parity_serial_tx_if.sv | 33 +++
 rtl/parity_serial_tx.sv | 126 ++++++++++++
 tb/tb_parity_serial_tx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/parity_serial_tx_if.sv
// Handshake and serial-line bundle for parity_serial_tx; master drives words, slave transmits.
// TX_PARITY_EVEN_SEL_EN adds the par_even select signal.
interface parity_serial_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              tx_bit;
   logic              tx_active;
   logic              tx_done;
`ifdef TX_PARITY_EVEN_SEL_EN
   logic              par_even;

   modport master (
      output din, din_valid, par_even,
      input  din_ready, tx_bit, tx_active, tx_done
   );
   modport slave (
      input  din, din_valid, par_even,
      output din_ready, tx_bit, tx_active, tx_done
   );
`else
   modport master (
      output din, din_valid,
      input  din_ready, tx_bit, tx_active, tx_done
   );
   modport slave (
      input  din, din_valid,
      output din_ready, tx_bit, tx_active, tx_done
   );
`endif
endinterface

// File: rtl/parity_serial_tx.sv
// LSB-first serial framer (start, data, parity, stop); start bit appears the cycle after the handshake.
// Accepts words only in IDLE (din_ready low while framing); TX_PARITY_EVEN_SEL_EN enables par_even.
module parity_serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic              clk,
   input  logic              rst,
   parity_serial_tx_if.slave bus
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam int IDX_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]  r_idx, w_idx_nxt;
   logic [DATA_W-1:0] r_shift, w_shift_nxt;
   logic              r_par, w_par_nxt;
   logic              r_tx_bit, w_tx_bit_nxt;
   logic              r_done, w_done_nxt;
   logic              w_bit_end;
   logic              w_accept;
   logic              w_par_in;

   assign w_bit_end = (r_cnt == CNT_LAST);
   assign w_accept  = (r_state == S_IDLE) && bus.din_valid;

`ifdef TX_PARITY_EVEN_SEL_EN
   assign w_par_in = bus.par_even ? (^bus.din) : (~^bus.din);
`else
   assign w_par_in = ~^bus.din;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = w_bit_end ? '0 : r_cnt + 1'b1;
      w_idx_nxt    = r_idx;
      w_shift_nxt  = r_shift;
      w_par_nxt    = r_par;
      w_done_nxt   = 1'b0;
      w_tx_bit_nxt = 1'b1;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (w_accept) begin
               w_shift_nxt = bus.din;
               w_par_nxt   = w_par_in;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_idx_nxt   = '0;
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_shift_nxt = r_shift >> 1;
               w_idx_nxt   = r_idx + 1'b1;
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // The line is registered, so drive it from what the next state will present.
      case (w_state_nxt)
         S_START:  w_tx_bit_nxt = 1'b0;
         S_DATA:   w_tx_bit_nxt = w_shift_nxt[0];
         S_PARITY: w_tx_bit_nxt = w_par_nxt;
         default:  w_tx_bit_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_tx_bit <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_idx    <= w_idx_nxt;
         r_shift  <= w_shift_nxt;
         r_par    <= w_par_nxt;
         r_tx_bit <= w_tx_bit_nxt;
         r_done   <= w_done_nxt;
      end
   end

   assign bus.din_ready = (r_state == S_IDLE);
   assign bus.tx_active = (r_state != S_IDLE);
   assign bus.tx_bit    = r_tx_bit;
   assign bus.tx_done   = r_done;
endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx at one and four clocks per bit.
module tb_parity_serial_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   parity_serial_tx_if #(.DATA_W(8)) bus1 ();
   parity_serial_tx_if #(.DATA_W(8)) bus4 ();

   parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called on the first negedge of a frame; returns on the tx_done negedge.
   task automatic watch1(input logic [10:0] exp, input string nm);
      for (int i = 0; i < 11; i++) begin
         check($sformatf("%s_bit%0d", nm, i), 32'(bus1.tx_bit), 32'(exp[i]));
         check($sformatf("%s_act%0d", nm, i), 32'(bus1.tx_active), 32'd1);
         check($sformatf("%s_rdy%0d", nm, i), 32'(bus1.din_ready), 32'd0);
         check($sformatf("%s_done%0d", nm, i), 32'(bus1.tx_done), 32'd0);
         @(negedge clk);
      end
      check({nm, "_done"}, 32'(bus1.tx_done), 32'd1);
      check({nm, "_idle_bit"}, 32'(bus1.tx_bit), 32'd1);
      check({nm, "_idle_act"}, 32'(bus1.tx_active), 32'd0);
      check({nm, "_idle_rdy"}, 32'(bus1.din_ready), 32'd1);
   endtask

   task automatic send1(input logic [7:0] d, input logic [10:0] exp, input string nm);
      bus1.din       = d;
      bus1.din_valid = 1'b1;
      @(negedge clk);
      bus1.din_valid = 1'b0;
      bus1.din       = ~d;
      watch1(exp, nm);
      @(negedge clk);
      check({nm, "_done_gone"}, 32'(bus1.tx_done), 32'd0);
   endtask

   initial begin
      int act_cnt;
      bus1.din       = '0;
      bus1.din_valid = 1'b0;
      bus4.din       = '0;
      bus4.din_valid = 1'b0;
`ifdef TX_PARITY_EVEN_SEL_EN
      bus1.par_even  = 1'b0;
      bus4.par_even  = 1'b0;
`endif

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_bit1", 32'(bus1.tx_bit), 32'd1);
      check("rst_rdy1", 32'(bus1.din_ready), 32'd1);
      check("rst_act1", 32'(bus1.tx_active), 32'd0);
      check("rst_done1", 32'(bus1.tx_done), 32'd0);
      check("rst_bit4", 32'(bus4.tx_bit), 32'd1);
      check("rst_rdy4", 32'(bus4.din_ready), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      // A5: 0 | 1,0,1,0,0,1,0,1 | par 1 | 1
      send1(8'hA5, 11'b11101001010, "a5");
      // 07: 0 | 1,1,1,0,0,0,0,0 | par 0 | 1
      send1(8'h07, 11'b10000001110, "x07");

      // Valid held high: 22 must wait, then go out right on the tx_done cycle.
      bus1.din       = 8'h11;
      bus1.din_valid = 1'b1;
      @(negedge clk);
      bus1.din = 8'h22;
      watch1(11'b11000100010, "b2b11");
      @(negedge clk);
      bus1.din_valid = 1'b0;
      watch1(11'b11001000100, "b2b22");
      @(negedge clk);
      check("b2b_done_gone", 32'(bus1.tx_done), 32'd0);

      // Abort during data bit 3 of A5.
      bus1.din       = 8'hA5;
      bus1.din_valid = 1'b1;
      @(negedge clk);
      bus1.din_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_pre_bit3", 32'(bus1.tx_bit), 32'd0);
      check("abort_pre_act", 32'(bus1.tx_active), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_bit", 32'(bus1.tx_bit), 32'd1);
      check("abort_rdy", 32'(bus1.din_ready), 32'd1);
      check("abort_act", 32'(bus1.tx_active), 32'd0);
      for (int i = 0; i < 12; i++) begin
         check($sformatf("abort_nodone%0d", i), 32'(bus1.tx_done), 32'd0);
         @(negedge clk);
      end
      send1(8'h07, 11'b10000001110, "post_abort");

      // 3C at 4 clocks per bit: 0 | 0,0,1,1,1,1,0,0 | par 1 | 1
      act_cnt        = 0;
      bus4.din       = 8'h3C;
      bus4.din_valid = 1'b1;
      @(negedge clk);
      bus4.din_valid = 1'b0;
      bus4.din       = 8'h00;
      for (int i = 0; i < 11; i++) begin
         for (int j = 0; j < 4; j++) begin
            check($sformatf("slow_bit%0d_%0d", i, j), 32'(bus4.tx_bit),
                  32'(i == 3 || i == 4 || i == 5 || i == 6 || i == 9 || i == 10));
            check($sformatf("slow_done%0d_%0d", i, j), 32'(bus4.tx_done), 32'd0);
            if (bus4.tx_active) act_cnt++;
            @(negedge clk);
         end
      end
      check("slow_act_cycles", 32'(act_cnt), 32'd44);
      check("slow_act_end", 32'(bus4.tx_active), 32'd0);
      check("slow_done", 32'(bus4.tx_done), 32'd1);
      check("slow_rdy", 32'(bus4.din_ready), 32'd1);
      @(negedge clk);
      check("slow_done_gone", 32'(bus4.tx_done), 32'd0);

`ifdef TX_PARITY_EVEN_SEL_EN
      // Even parity on A5 (four ones) gives a 0 parity bit.
      bus1.par_even = 1'b1;
      send1(8'hA5, 11'b10101001010, "even_a5");
      bus1.par_even = 1'b0;
      send1(8'hA5, 11'b11101001010, "odd_a5");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
